mux_2to1_arbiter: RTL and testbench



---
 rtl/mux_arb_pkg.sv | 23 ++
 rtl/mux_2to1_arbiter_if.sv | 27 ++
 rtl/mux_2to1.sv | 9 +
 rtl/mux_2to1_arbiter.sv | 155 +++++++++++++++
 tb/tb_mux_2to1_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the two-requester round-robin arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_A = 2'd1,
    ARB_OWN_B = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_A) ? SRC_B : SRC_A;
  endfunction

  function automatic arb_state_e own_state(input src_e s);
    return (s == SRC_A) ? ARB_OWN_A : ARB_OWN_B;
  endfunction

endpackage

// File: rtl/mux_2to1_arbiter_if.sv
// Stream bundle between the two requesters, the arbiter and the shared sink.
// slave: arbiter side; master: producers/sink side.
interface mux_2to1_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  logic              a_valid_i;
  logic              a_ready_o;
  logic [DATA_W-1:0] a_data_i;
  logic              b_valid_i;
  logic              b_ready_o;
  logic [DATA_W-1:0] b_data_i;
  logic              y_valid_o;
  logic              y_ready_i;
  logic [DATA_W-1:0] y_data_o;
  logic              sel_o;
  logic              busy_o;

  modport slave (
    input  a_valid_i, a_data_i, b_valid_i, b_data_i, y_ready_i,
    output a_ready_o, b_ready_o, y_valid_o, y_data_o, sel_o, busy_o
  );

  modport master (
    output a_valid_i, a_data_i, b_valid_i, b_data_i, y_ready_i,
    input  a_ready_o, b_ready_o, y_valid_o, y_data_o, sel_o, busy_o
  );
endinterface

// File: rtl/mux_2to1.sv
// Existing 1-bit 2:1 mux cell: sel_i=0 passes a_i, sel_i=1 passes b_i.
module mux_2to1 (
  input  logic a_i,
  input  logic b_i,
  input  logic sel_i,
  output logic y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

// File: rtl/mux_2to1_arbiter.sv
// Round-robin, burst-limited arbiter sharing one registered 2:1 data path
// between stream requesters A and B.
// Optional grant statistics counters: define MUX_ARB_STATS_EN.
//
// state     | meaning
// ARB_IDLE  | no owner; contention goes to the requester != last_grant
// ARB_OWN_A | A took the last beat; keeps grant until burst limit with B waiting
// ARB_OWN_B | B took the last beat; keeps grant until burst limit with A waiting
module mux_2to1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
`ifdef MUX_ARB_STATS_EN
  , parameter int unsigned CNT_W   = 16
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
`ifdef MUX_ARB_STATS_EN
  output logic [CNT_W-1:0] gnt_cnt_a_o,
  output logic [CNT_W-1:0] gnt_cnt_b_o,
`endif
  mux_2to1_arbiter_if.slave bus
);

  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  arb_state_e         state_q, state_d;
  src_e               last_q, last_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               y_valid_q, y_valid_d;
  logic [DATA_W-1:0]  y_data_q, y_data_d;
  src_e               sel_q, sel_d;
`ifdef MUX_ARB_STATS_EN
  logic [CNT_W-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
`endif

  src_e              gnt;
  src_e              owner;
  logic              out_ready;
  logic              gnt_valid;
  logic              xfer;
  logic [DATA_W-1:0] mux_y;

  // Data steering through the existing bit-slice mux cell.
  for (genvar k = 0; k < DATA_W; k++) begin : g_mux
    mux_2to1 u_mux (
      .a_i   (bus.a_data_i[k]),
      .b_i   (bus.b_data_i[k]),
      .sel_i (gnt),
      .y_o   (mux_y[k])
    );
  end

  // Grant decision: owner keeps the grant until the burst limit while the
  // other side waits; a saturated owner keeps going only if the other is idle.
  always_comb begin
    gnt   = SRC_A;
    owner = (state_q == ARB_OWN_B) ? SRC_B : SRC_A;
    unique case (state_q)
      ARB_OWN_A: begin
        if (bus.a_valid_i && (burst_q < BURST_MAX || !bus.b_valid_i)) gnt = SRC_A;
        else if (bus.b_valid_i)                                       gnt = SRC_B;
        else                                                          gnt = SRC_A;
      end
      ARB_OWN_B: begin
        if (bus.b_valid_i && (burst_q < BURST_MAX || !bus.a_valid_i)) gnt = SRC_B;
        else if (bus.a_valid_i)                                       gnt = SRC_A;
        else                                                          gnt = SRC_B;
      end
      default: begin
        if (bus.a_valid_i && bus.b_valid_i) gnt = other_src(last_q);
        else if (bus.b_valid_i)             gnt = SRC_B;
        else                                gnt = SRC_A;
      end
    endcase
    out_ready = !y_valid_q || bus.y_ready_i;
    gnt_valid = (gnt == SRC_A) ? bus.a_valid_i : bus.b_valid_i;
    xfer      = out_ready && gnt_valid;
  end

  // Next-state for FSM, burst tracking and output register; everything
  // freezes while the sink stalls a valid output beat.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    burst_d   = burst_q;
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    sel_d     = sel_q;
    if (out_ready) begin
      y_valid_d = xfer;
      if (xfer) begin
        state_d  = own_state(gnt);
        last_d   = gnt;
        y_data_d = mux_y;
        sel_d    = gnt;
        if (state_q == ARB_IDLE || gnt != owner || burst_q == BURST_MAX)
          burst_d = BURST_W'(1);
        else
          burst_d = burst_q + 1'b1;
      end else begin
        state_d = ARB_IDLE;
      end
    end
`ifdef MUX_ARB_STATS_EN
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (xfer && gnt == SRC_A && cnt_a_q != '1) cnt_a_d = cnt_a_q + 1'b1;
    if (xfer && gnt == SRC_B && cnt_b_q != '1) cnt_b_d = cnt_b_q + 1'b1;
`endif
  end

  // All arbiter state and the output stage; last_grant resets to B so A
  // wins the first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ARB_IDLE;
      last_q    <= SRC_B;
      burst_q   <= '0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      sel_q     <= SRC_A;
`ifdef MUX_ARB_STATS_EN
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      sel_q     <= sel_d;
`ifdef MUX_ARB_STATS_EN
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
`endif
    end
  end

  assign bus.a_ready_o = xfer && (gnt == SRC_A);
  assign bus.b_ready_o = xfer && (gnt == SRC_B);
  assign bus.y_valid_o = y_valid_q;
  assign bus.y_data_o  = y_data_q;
  assign bus.sel_o     = sel_q;
  assign bus.busy_o    = (state_q != ARB_IDLE) || y_valid_q;
`ifdef MUX_ARB_STATS_EN
  assign gnt_cnt_a_o   = cnt_a_q;
  assign gnt_cnt_b_o   = cnt_b_q;
`endif

endmodule

// File: tb/tb_mux_2to1_arbiter.sv
// Directed bench for mux_2to1_arbiter: one instance with MAX_BURST=4 and one
// with MAX_BURST=1, both fed the same stimulus.
// Statistics checks compile in with MUX_ARB_STATS_EN.
module tb_mux_2to1_arbiter;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  mux_2to1_arbiter_if #(.DATA_W(8)) bus4 ();
  mux_2to1_arbiter_if #(.DATA_W(8)) bus1 ();

`ifdef MUX_ARB_STATS_EN
  logic [1:0]  cnt_a4, cnt_b4;
  logic [15:0] cnt_a1, cnt_b1;
`endif

  mux_2to1_arbiter #(
    .DATA_W(8), .MAX_BURST(4)
`ifdef MUX_ARB_STATS_EN
    , .CNT_W(2)
`endif
  ) dut4 (
    .clk_i(clk_sys), .rst_ni(rst_n),
`ifdef MUX_ARB_STATS_EN
    .gnt_cnt_a_o(cnt_a4), .gnt_cnt_b_o(cnt_b4),
`endif
    .bus(bus4.slave)
  );

  mux_2to1_arbiter #(
    .DATA_W(8), .MAX_BURST(1)
`ifdef MUX_ARB_STATS_EN
    , .CNT_W(16)
`endif
  ) dut1 (
    .clk_i(clk_sys), .rst_ni(rst_n),
`ifdef MUX_ARB_STATS_EN
    .gnt_cnt_a_o(cnt_a1), .gnt_cnt_b_o(cnt_b1),
`endif
    .bus(bus1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [7:0] ad,
                       input logic bv, input logic [7:0] bd, input logic yr);
    bus4.a_valid_i = av; bus4.a_data_i = ad;
    bus4.b_valid_i = bv; bus4.b_data_i = bd; bus4.y_ready_i = yr;
    bus1.a_valid_i = av; bus1.a_data_i = ad;
    bus1.b_valid_i = bv; bus1.b_data_i = bd; bus1.y_ready_i = yr;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 rst_n = 1'b1;
  endtask

  logic exp_src [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic alt_src [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    do_reset();

    // reset state
    @(negedge clk_sys);
    chk("rst_y_valid", bus4.y_valid_o, 1'b0);
    chk("rst_y_data",  bus4.y_data_o,  8'h00);
    chk("rst_sel",     bus4.sel_o,     1'b0);
    chk("rst_busy",    bus4.busy_o,    1'b0);
    chk("rst_a_ready", bus4.a_ready_o, 1'b0);
    chk("rst_b_ready", bus4.b_ready_o, 1'b0);
    tick();

    // A only: 11, 22
    drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
    @(negedge clk_sys);
    chk("aonly_a_ready0", bus4.a_ready_o, 1'b1);
    chk("aonly_b_ready0", bus4.b_ready_o, 1'b0);
    chk("aonly_y_valid0", bus4.y_valid_o, 1'b0);
    tick();
    drive(1'b1, 8'h22, 1'b0, 8'h00, 1'b1);
    @(negedge clk_sys);
    chk("aonly_a_ready1", bus4.a_ready_o, 1'b1);
    chk("aonly_b_ready1", bus4.b_ready_o, 1'b0);
    chk("aonly_y_valid1", bus4.y_valid_o, 1'b1);
    chk("aonly_y_data1",  bus4.y_data_o,  8'h11);
    chk("aonly_sel1",     bus4.sel_o,     1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    @(negedge clk_sys);
    chk("aonly_y_data2",  bus4.y_data_o,  8'h22);
    chk("aonly_b_ready2", bus4.b_ready_o, 1'b0);
    tick();
    @(negedge clk_sys);
    chk("aonly_y_valid3", bus4.y_valid_o, 1'b0);
    chk("aonly_busy3",    bus4.busy_o,    1'b0);

    // contention, MAX_BURST=4: A,A,A,A,B,B,B,B,A
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'hA0 + 8'(i), 1'b1, 8'hB0 + 8'(i), 1'b1);
      @(negedge clk_sys);
      if (i < 9) begin
        chk($sformatf("cont_a_ready%0d", i), bus4.a_ready_o, !exp_src[i]);
        chk($sformatf("cont_b_ready%0d", i), bus4.b_ready_o, exp_src[i]);
      end
      if (i > 0) begin
        chk($sformatf("cont_sel%0d", i), bus4.sel_o, exp_src[i-1]);
        chk($sformatf("cont_data%0d", i), bus4.y_data_o,
            exp_src[i-1] ? 8'hB0 + 8'(i-1) : 8'hA0 + 8'(i-1));
      end
      tick();
    end

    // MAX_BURST=1: strict alternation, then B only
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h40 + 8'(i), 1'b1, 8'h50 + 8'(i), 1'b1);
      @(negedge clk_sys);
      chk($sformatf("alt_a_ready%0d", i), bus1.a_ready_o, !alt_src[i]);
      chk($sformatf("alt_b_ready%0d", i), bus1.b_ready_o, alt_src[i]);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b1, 8'h60 + 8'(i), 1'b1);
      @(negedge clk_sys);
      chk($sformatf("bonly_b_ready%0d", i), bus1.b_ready_o, 1'b1);
      chk($sformatf("bonly_a_ready%0d", i), bus1.a_ready_o, 1'b0);
      if (i > 0) chk($sformatf("bonly_data%0d", i), bus1.y_data_o, 8'h60 + 8'(i-1));
      tick();
    end

    // backpressure with 5A held
    do_reset();
    drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h6B, 1'b1, 8'h7C, 1'b0);
      @(negedge clk_sys);
      chk($sformatf("bp_a_ready%0d", i), bus4.a_ready_o, 1'b0);
      chk($sformatf("bp_b_ready%0d", i), bus4.b_ready_o, 1'b0);
      chk($sformatf("bp_y_valid%0d", i), bus4.y_valid_o, 1'b1);
      chk($sformatf("bp_y_data%0d", i),  bus4.y_data_o,  8'h5A);
      chk($sformatf("bp_sel%0d", i),     bus4.sel_o,     1'b0);
      tick();
    end
    drive(1'b1, 8'h6B, 1'b1, 8'h7C, 1'b1);
    @(negedge clk_sys);
    chk("bp_rel_a_ready", bus4.a_ready_o, 1'b1);
    chk("bp_rel_y_data",  bus4.y_data_o,  8'h5A);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    @(negedge clk_sys);
    chk("bp_next_y_valid", bus4.y_valid_o, 1'b1);
    chk("bp_next_y_data",  bus4.y_data_o,  8'h6B);
    chk("bp_next_sel",     bus4.sel_o,     1'b0);
    tick();
    @(negedge clk_sys);
    chk("bp_no_dup", bus4.y_valid_o, 1'b0);

    // async reset mid-burst
    do_reset();
    drive(1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #2;
    chk("arst_pre_y_valid", bus4.y_valid_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_y_valid", bus4.y_valid_o, 1'b0);
    chk("arst_y_data",  bus4.y_data_o,  8'h00);
    chk("arst_busy",    bus4.busy_o,    1'b0);
    #2 rst_n = 1'b1;
    drive(1'b1, 8'h44, 1'b1, 8'h55, 1'b1);
    @(negedge clk_sys);
    chk("arst_first_a", bus4.a_ready_o, 1'b1);
    chk("arst_first_b", bus4.b_ready_o, 1'b0);
    tick();

`ifdef MUX_ARB_STATS_EN
    do_reset();
    @(negedge clk_sys);
    chk("stats_rst_a", cnt_a4, 2'b00);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h90 + 8'(i), 1'b0, 8'h00, 1'b1);
      tick();
      if (i == 0) chk("stats_a_one", cnt_a4, 2'b01);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    @(negedge clk_sys);
    chk("stats_a_sat", cnt_a4, 2'b11);
    chk("stats_b_zero", cnt_b4, 2'b00);
    chk("stats_a_wide", cnt_a1, 16'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
